// File: rtl/pl_lsu.sv
// Memory-stage load/store unit: one data-bus transaction per load/store, store lane/strobe formatting, load extraction/extension.
// Latency: k+1 stall cycles for mem_ready in cycle k (minimum 2); backpressure: StallM holds upstream until DONE; faults never stall.
module pl_lsu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  Funct3M,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] offset;
    } accCtl_t;

    logic [1:0]  state;
    accCtl_t     ctl;
    logic        isStore;
    logic        isLoad;
    logic        isAccess;
    logic        misaligned;
    logic        illegal;
    logic        accFault;
    logic        accValid;
    logic [31:0] storeData;
    logic [3:0]  storeStrb;
    logic [31:0] lane;
    logic [31:0] loadData;

    // Store wins when both a store and a load are flagged.
    always_comb begin
        isStore    = MemWriteM;
        isLoad     = (ResultSrcM == 2'b01) && RegWriteM && !MemWriteM;
        isAccess   = isStore || isLoad;
        misaligned = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                     ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
        if (isStore)
            illegal = !((Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010));
        else
            illegal = (Funct3M == 3'b011) || (Funct3M == 3'b110) || (Funct3M == 3'b111);
        accFault = isAccess && (misaligned || illegal);
        FaultM   = (state == IDLE) && accFault;
        accValid = (state == IDLE) && isAccess && !accFault;
        StallM   = accValid || (state == BUSY);
    end

    always_comb begin
        storeData = WriteDataM;
        storeStrb = 4'b1111;
        case (Funct3M[1:0])
            2'b00: begin
                storeData = {4{WriteDataM[7:0]}};
                storeStrb = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                storeData = {2{WriteDataM[15:0]}};
                storeStrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                storeData = WriteDataM;
                storeStrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        lane = mem_rdata >> {ctl.offset, 3'b000};
        case (ctl.funct3)
            3'b000:  loadData = {{24{lane[7]}}, lane[7:0]};
            3'b001:  loadData = {{16{lane[15]}}, lane[15:0]};
            3'b100:  loadData = {24'd0, lane[7:0]};
            3'b101:  loadData = {16'd0, lane[15:0]};
            default: loadData = lane;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ctl       <= '0;
            ReadDataM <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accValid) begin
                        ctl.funct3 <= Funct3M;
                        ctl.offset <= ALUResultM[1:0];
                        mem_req    <= 1'b1;
                        mem_we     <= isStore;
                        mem_addr   <= {ALUResultM[31:2], 2'b00};
                        mem_wdata  <= isStore ? storeData : 32'd0;
                        mem_wstrb  <= isStore ? storeStrb : 4'b0000;
                        state      <= BUSY;
                    end else if (FaultM) begin
                        ReadDataM <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (!mem_we)
                            ReadDataM <= loadData;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                // The instruction still presented here was already serviced.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_lsu.sv
// Directed bench for pl_lsu: inputs driven and outputs sampled around the falling clock edge.
module tb_pl_lsu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [2:0]  Funct3M = '0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        FaultM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int nVec = 0;
    int nMiss = 0;
    int busWrites = 0;
    int busReads = 0;
    int stallCnt;
    int w0;
    int r0;
    logic [31:0] lastAddr = '0;
    logic [31:0] lastWdata = '0;
    logic [3:0]  lastStrb = '0;

    pl_lsu dut (
        .clk(clk), .reset_n(reset_n), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .Funct3M(Funct3M), .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Bus-side monitor: every accepted transaction is counted and captured.
    always @(posedge clk) begin
        if (reset_n && mem_req && mem_ready) begin
            if (mem_we) begin
                busWrites++;
                lastAddr  = mem_addr;
                lastWdata = mem_wdata;
                lastStrb  = mem_wstrb;
            end else begin
                busReads++;
                lastAddr = mem_addr;
            end
        end
    end

    task automatic present(input logic st, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = st;
        RegWriteM  = ld;
        ResultSrcM = ld ? 2'b01 : 2'b00;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = d;
    endtask

    task automatic idleInputs();
        present(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    // Presents an access in cycle 0, answers in cycle k, returns sampled in the DONE cycle.
    task automatic runAccess(input logic st, input logic ld, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rdata, input int k);
        @(negedge clk);
        present(st, ld, f3, a, d);
        mem_ready = 1'b0;
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            mem_ready = (i == k);
            mem_rdata = (i == k) ? rdata : 32'hCCCCCCCC;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hCCCCCCCC;
        #1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        nVec++; if (ReadDataM !== 32'd0) begin nMiss++; $display("FAIL rst_rdata: got %h want 0", ReadDataM); end
        nVec++; if ({mem_req, mem_we, mem_wstrb} !== 6'd0) begin nMiss++; $display("FAIL rst_bus_ctl: got %b want 0", {mem_req, mem_we, mem_wstrb}); end
        nVec++; if ({mem_addr, mem_wdata} !== 64'd0) begin nMiss++; $display("FAIL rst_bus_dat: got %h want 0", {mem_addr, mem_wdata}); end
        nVec++; if ({StallM, FaultM} !== 2'b00) begin nMiss++; $display("FAIL rst_stall_fault: got %b want 00", {StallM, FaultM}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        nVec++; if ({StallM, FaultM, mem_req} !== 3'b000) begin nMiss++; $display("FAIL rst_idle: got %b want 000", {StallM, FaultM, mem_req}); end
    endtask

    task automatic test_store_byte();
        w0 = busWrites;
        @(negedge clk);
        present(1'b1, 1'b0, 3'b000, 32'h00001003, 32'h000000A5);
        #1;
        nVec++; if ({StallM, FaultM, mem_req} !== 3'b100) begin nMiss++; $display("FAIL sb_c0: got %b want 100", {StallM, FaultM, mem_req}); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        nVec++; if ({StallM, mem_req, mem_we} !== 3'b111) begin nMiss++; $display("FAIL sb_c1_ctl: got %b want 111", {StallM, mem_req, mem_we}); end
        nVec++; if (mem_addr !== 32'h00001000) begin nMiss++; $display("FAIL sb_addr: got %h want 00001000", mem_addr); end
        nVec++; if (mem_wdata !== 32'hA5A5A5A5) begin nMiss++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); end
        nVec++; if (mem_wstrb !== 4'b1000) begin nMiss++; $display("FAIL sb_wstrb: got %b want 1000", mem_wstrb); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nVec++; if ({StallM, mem_req} !== 2'b00) begin nMiss++; $display("FAIL sb_c2: got %b want 00", {StallM, mem_req}); end
        @(negedge clk);
        idleInputs();
        #1;
        nVec++; if (mem_req !== 1'b0) begin nMiss++; $display("FAIL sb_no_reissue: got %b want 0", mem_req); end
        nVec++; if (busWrites - w0 !== 1) begin nMiss++; $display("FAIL sb_count: got %0d want 1", busWrites - w0); end
    endtask

    task automatic test_store_half();
        runAccess(1'b1, 1'b0, 3'b001, 32'h00001002, 32'h1234ABCD, 32'h0, 1);
        @(negedge clk); idleInputs();
        nVec++; if (lastWdata !== 32'hABCDABCD) begin nMiss++; $display("FAIL sh_wdata: got %h want abcdabcd", lastWdata); end
        nVec++; if (lastStrb !== 4'b1100) begin nMiss++; $display("FAIL sh_wstrb: got %b want 1100", lastStrb); end
        runAccess(1'b1, 1'b0, 3'b001, 32'h00001000, 32'h00005A5A, 32'h0, 1);
        @(negedge clk); idleInputs();
        nVec++; if (lastStrb !== 4'b0011) begin nMiss++; $display("FAIL sh_lo_wstrb: got %b want 0011", lastStrb); end
    endtask

    task automatic test_load_byte();
        runAccess(1'b0, 1'b1, 3'b000, 32'h00002002, 32'h0, 32'h12F03456, 1);
        nVec++; if (ReadDataM !== 32'hFFFFFFF0) begin nMiss++; $display("FAIL lb: got %h want fffffff0", ReadDataM); end
        nVec++; if (StallM !== 1'b0) begin nMiss++; $display("FAIL lb_done_stall: got %b want 0", StallM); end
        @(negedge clk); idleInputs();
        runAccess(1'b0, 1'b1, 3'b100, 32'h00002002, 32'h0, 32'h12F03456, 1);
        nVec++; if (ReadDataM !== 32'h000000F0) begin nMiss++; $display("FAIL lbu: got %h want 000000f0", ReadDataM); end
        @(negedge clk); idleInputs();
        runAccess(1'b0, 1'b1, 3'b010, 32'h00003000, 32'h0, 32'hDEADBEEF, 1);
        nVec++; if (ReadDataM !== 32'hDEADBEEF) begin nMiss++; $display("FAIL lw: got %h want deadbeef", ReadDataM); end
        @(negedge clk); idleInputs();
    endtask

    task automatic test_load_half_wait();
        stallCnt = 0;
        @(negedge clk);
        present(1'b0, 1'b1, 3'b001, 32'h00002002, 32'h0);
        mem_rdata = 32'hCCCCCCCC;
        #1;
        if (StallM) stallCnt++;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            mem_ready = (c == 3);
            mem_rdata = (c == 3) ? 32'h80001234 : 32'hCCCCCCCC;
            #1;
            if (StallM) stallCnt++;
            nVec++; if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {2'b10, 32'h00002000, 4'b0000}) begin
                nMiss++; $display("FAIL lh_bus_c%0d: got req=%b we=%b addr=%h strb=%b want 1 0 00002000 0000", c, mem_req, mem_we, mem_addr, mem_wstrb);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        if (StallM) stallCnt++;
        nVec++; if (ReadDataM !== 32'hFFFF8000) begin nMiss++; $display("FAIL lh: got %h want ffff8000", ReadDataM); end
        nVec++; if (stallCnt !== 4) begin nMiss++; $display("FAIL lh_stall_cycles: got %0d want 4", stallCnt); end
        @(negedge clk); idleInputs();
        runAccess(1'b0, 1'b1, 3'b101, 32'h00002002, 32'h0, 32'h80001234, 2);
        nVec++; if (ReadDataM !== 32'h00008000) begin nMiss++; $display("FAIL lhu: got %h want 00008000", ReadDataM); end
        @(negedge clk); idleInputs();
    endtask

    task automatic test_fault();
        w0 = busWrites;
        r0 = busReads;
        @(negedge clk);
        present(1'b0, 1'b1, 3'b010, 32'h00003002, 32'h0);
        #1;
        nVec++; if ({FaultM, StallM} !== 2'b10) begin nMiss++; $display("FAIL lw_misalign: got %b want 10", {FaultM, StallM}); end
        @(negedge clk);
        present(1'b0, 1'b1, 3'b011, 32'h00003000, 32'h0);
        #1;
        nVec++; if ({FaultM, StallM, mem_req} !== 3'b100) begin nMiss++; $display("FAIL ld_f3_011: got %b want 100", {FaultM, StallM, mem_req}); end
        nVec++; if (ReadDataM !== 32'd0) begin nMiss++; $display("FAIL fault_rdata_zero: got %h want 0", ReadDataM); end
        @(negedge clk);
        present(1'b1, 1'b0, 3'b100, 32'h00005000, 32'h0);
        #1;
        nVec++; if ({FaultM, StallM, mem_req} !== 3'b100) begin nMiss++; $display("FAIL st_f3_100: got %b want 100", {FaultM, StallM, mem_req}); end
        @(negedge clk);
        present(1'b1, 1'b0, 3'b001, 32'h00005001, 32'h0);
        #1;
        nVec++; if ({FaultM, StallM, mem_req} !== 3'b100) begin nMiss++; $display("FAIL sh_misalign: got %b want 100", {FaultM, StallM, mem_req}); end
        @(negedge clk);
        idleInputs();
        #1;
        nVec++; if ({FaultM, mem_req} !== 2'b00) begin nMiss++; $display("FAIL fault_quiet: got %b want 00", {FaultM, mem_req}); end
        nVec++; if ((busWrites - w0) + (busReads - r0) !== 0) begin nMiss++; $display("FAIL fault_bus: got %0d want 0", (busWrites - w0) + (busReads - r0)); end
    endtask

    task automatic test_back_to_back();
        w0 = busWrites;
        @(negedge clk);
        present(1'b1, 1'b0, 3'b010, 32'h00004000, 32'h11223344);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nVec++; if (StallM !== 1'b0) begin nMiss++; $display("FAIL b2b_done1: got %b want 0", StallM); end
        nVec++; if (lastAddr !== 32'h00004000) begin nMiss++; $display("FAIL b2b_addr1: got %h want 00004000", lastAddr); end
        @(negedge clk);
        present(1'b1, 1'b0, 3'b010, 32'h00004004, 32'h55667788);
        #1;
        nVec++; if ({StallM, mem_req} !== 2'b10) begin nMiss++; $display("FAIL b2b_idle2: got %b want 10", {StallM, mem_req}); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        nVec++; if (mem_req !== 1'b1) begin nMiss++; $display("FAIL b2b_req2: got %b want 1", mem_req); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nVec++; if (StallM !== 1'b0) begin nMiss++; $display("FAIL b2b_done2: got %b want 0", StallM); end
        nVec++; if ({lastAddr, lastWdata, lastStrb} !== {32'h00004004, 32'h55667788, 4'b1111}) begin
            nMiss++; $display("FAIL b2b_w2: got %h %h %b want 00004004 55667788 1111", lastAddr, lastWdata, lastStrb);
        end
        @(negedge clk);
        idleInputs();
        #1;
        nVec++; if (mem_req !== 1'b0) begin nMiss++; $display("FAIL b2b_no_dup: got %b want 0", mem_req); end
        nVec++; if (busWrites - w0 !== 2) begin nMiss++; $display("FAIL b2b_count: got %0d want 2", busWrites - w0); end
    endtask

    task automatic test_reset_busy();
        runAccess(1'b0, 1'b1, 3'b010, 32'h00003000, 32'h0, 32'hCAFEF00D, 1);
        nVec++; if (ReadDataM !== 32'hCAFEF00D) begin nMiss++; $display("FAIL rb_pre: got %h want cafef00d", ReadDataM); end
        @(negedge clk);
        present(1'b0, 1'b1, 3'b010, 32'h00003004, 32'h0);
        @(negedge clk);
        #1;
        nVec++; if (mem_req !== 1'b1) begin nMiss++; $display("FAIL rb_busy: got %b want 1", mem_req); end
        reset_n = 1'b0;
        idleInputs();
        #1;
        nVec++; if ({mem_req, StallM, mem_wstrb} !== 6'd0) begin nMiss++; $display("FAIL rb_ctl: got %b want 0", {mem_req, StallM, mem_wstrb}); end
        nVec++; if ({ReadDataM, mem_addr} !== 64'd0) begin nMiss++; $display("FAIL rb_dat: got %h want 0", {ReadDataM, mem_addr}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        nVec++; if (mem_req !== 1'b0) begin nMiss++; $display("FAIL rb_no_retry: got %b want 0", mem_req); end
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half();
        test_load_byte();
        test_load_half_wait();
        test_fault();
        test_back_to_back();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
